// File: rtl/serializer_if.sv
// Queue-side and serial-link signals of the serializer, bundled so the
// producer (queue/link model) and the serializer see one consistent view.
interface serializer_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
);
  logic             enable_in;
  logic [LEN_W-1:0] len_in;
  logic [WIDTH-1:0] data_in;
  logic             rx_status_in;
  logic             dequeue_out;
  logic             serial_out;
  logic             write_out;
  logic             busy_out;
  logic             done_out;

  modport master (
    output enable_in, len_in, data_in, rx_status_in,
    input  dequeue_out, serial_out, write_out, busy_out, done_out
  );

  modport slave (
    input  enable_in, len_in, data_in, rx_status_in,
    output dequeue_out, serial_out, write_out, busy_out, done_out
  );
endinterface

// File: rtl/serializer.sv
// Pops words from the queue head and shifts them out MSB first, one strobed
// bit per cycle when the receiver is ready; all outputs are registered.
module serializer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input logic         clock,
  input logic         reset,
  serializer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam int                CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state,   w_next_state;
  logic [WIDTH-1:0] r_shift,   w_shift_next;
  logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_next;
  logic             r_serial,  w_serial_next;
  logic             r_write,   w_write_next;
  logic             r_dequeue, w_dequeue_next;
  logic             r_busy,    w_busy_next;
  logic             r_done,    w_done_next;

  logic w_start;
  logic w_last;

  assign w_start = bus.enable_in && (bus.len_in != '0) && bus.rx_status_in;
  assign w_last  = (r_bit_cnt == LAST_BIT);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_serial  <= 1'b0;
      r_write   <= 1'b0;
      r_dequeue <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_serial  <= w_serial_next;
      r_write   <= w_write_next;
      r_dequeue <= w_dequeue_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
    end
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next_state = S_SHIFT;
      S_SHIFT: if (bus.rx_status_in && w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // A receiver stall in SHIFT only clears the strobe; the word and count hold.
  always_comb begin
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_serial_next  = r_serial;
    w_write_next   = 1'b0;
    w_dequeue_next = 1'b0;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_shift_next   = bus.data_in;
          w_bit_cnt_next = '0;
          w_dequeue_next = 1'b1;
          w_busy_next    = 1'b1;
        end
      end
      S_SHIFT: begin
        if (bus.rx_status_in) begin
          w_serial_next  = r_shift[WIDTH-1];
          w_write_next   = 1'b1;
          w_shift_next   = r_shift << 1;
          w_bit_cnt_next = r_bit_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_busy_next = 1'b0;
        w_done_next = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.dequeue_out = r_dequeue;
  assign bus.serial_out  = r_serial;
  assign bus.write_out   = r_write;
  assign bus.busy_out    = r_busy;
  assign bus.done_out    = r_done;

endmodule
